// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory behind a valid/ready request and
// response handshake, answering each request after LATENCY wait cycles.
module dmem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_cnt;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic [31:0]   r_mem [DEPTH];

   logic          w_accept;
   logic          w_enter_resp;
   logic          w_acc_we;
   logic [31:0]   w_acc_addr;
   logic [31:0]   w_acc_wdata;
   logic          w_acc_err;
   logic [AW-1:0] w_idx;

   // With LATENCY=0 the access happens on the accept edge itself, before the
   // request registers hold the request, so the live inputs are used instead.
   assign w_accept     = req_valid_i && (r_state == IDLE);
   assign w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);
   assign w_acc_we     = (r_state == IDLE) ? req_we_i    : r_we;
   assign w_acc_addr   = (r_state == IDLE) ? req_addr_i  : r_addr;
   assign w_acc_wdata  = (r_state == IDLE) ? req_wdata_i : r_wdata;
   assign w_acc_err    = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:2] >= 30'(DEPTH));
   assign w_idx        = w_acc_addr[AW+1:2];

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt  = r_state;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_rdata_o = r_rdata;
      resp_err_o   = r_err;
      case (r_state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               w_state_nxt = (LATENCY == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request capture, wait counter and registered response.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we    <= req_we_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_cnt   <= LAT_LOAD;
         end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 4'd1;
         end

         if (w_enter_resp) begin
            r_err   <= w_acc_err;
            r_rdata <= (!w_acc_we && !w_acc_err) ? r_mem[w_idx] : '0;
         end else if ((r_state == RESP) && resp_ready_i) begin
            r_err   <= 1'b0;
            r_rdata <= '0;
         end
      end
   end

   // Storage is never cleared; writes are suppressed while reset is held so a
   // request presented during reset cannot commit.
   always_ff @(posedge clk_i) begin
      if (rst_n_i && w_enter_resp && w_acc_we && !w_acc_err) begin
         r_mem[w_idx] <= w_acc_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 0, 4; DEPTH 256)
// driven with directed and random requests against a word-array model.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid  [3];
   logic        req_ready  [3];
   logic        req_we     [3];
   logic [31:0] req_addr   [3];
   logic [31:0] req_wdata  [3];
   logic        resp_valid [3];
   logic        resp_ready [3];
   logic [31:0] resp_rdata [3];
   logic        resp_err   [3];

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   int          lat_of [3] = '{2, 0, 4};

   logic [31:0] mdl_mem [3][256];
   bit          mdl_vld [3][256];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 0 : 4);
         dmem_responder #(.DEPTH(256), .LATENCY(LAT)) u_dut (
            .clk_i        (clk),
            .rst_n_i      (rst_n),
            .req_valid_i  (req_valid[g]),
            .req_ready_o  (req_ready[g]),
            .req_we_i     (req_we[g]),
            .req_addr_i   (req_addr[g]),
            .req_wdata_i  (req_wdata[g]),
            .resp_valid_o (resp_valid[g]),
            .resp_ready_i (resp_ready[g]),
            .resp_rdata_o (resp_rdata[g]),
            .resp_err_o   (resp_err[g])
         );
      end
   endgenerate

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_idle_outputs(input int k, input string tag);
      chk($sformatf("d%0d %s req_ready", k, tag), 32'(req_ready[k]), 32'd1);
      chk($sformatf("d%0d %s resp_valid", k, tag), 32'(resp_valid[k]), 32'd0);
      chk($sformatf("d%0d %s rdata", k, tag), resp_rdata[k], 32'd0);
      chk($sformatf("d%0d %s err", k, tag), 32'(resp_err[k]), 32'd0);
   endtask

   // One complete transaction; entered and left at posedge+1 with DUT k idle.
   task automatic txn(input int k, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold, input bit intrude,
                      output int unsigned acc_cyc);
      bit          err;
      bit          chkdata;
      int unsigned w;
      logic [31:0] exp_rd;
      logic [31:0] sv_rd;
      logic        sv_err;
      int          n;
      err     = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd256);
      w       = addr[9:2];
      exp_rd  = '0;
      chkdata = 1'b1;
      if (!err) begin
         if (we) begin
            mdl_mem[k][w] = wdata;
            mdl_vld[k][w] = 1'b1;
         end else if (mdl_vld[k][w]) begin
            exp_rd = mdl_mem[k][w];
         end else begin
            chkdata = 1'b0;
         end
      end

      chk($sformatf("d%0d req_ready before request", k), 32'(req_ready[k]), 32'd1);
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = addr;
      req_wdata[k] = wdata;
      @(posedge clk); #1;
      acc_cyc = cyc;
      // Disturb the request lines; an optional competing write must be ignored.
      req_valid[k] = intrude;
      req_we[k]    = 1'b1;
      req_addr[k]  = addr;
      req_wdata[k] = ~wdata;

      n = 0;
      while (resp_valid[k] !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("d%0d latency addr=%08h", k, addr), 32'(n), 32'(lat_of[k]));
      if (chkdata) chk($sformatf("d%0d rdata addr=%08h", k, addr), resp_rdata[k], exp_rd);
      chk($sformatf("d%0d err addr=%08h", k, addr), 32'(resp_err[k]), 32'(err));
      sv_rd  = resp_rdata[k];
      sv_err = resp_err[k];

      repeat (hold) begin
         @(posedge clk); #1;
         chk($sformatf("d%0d hold resp_valid", k), 32'(resp_valid[k]), 32'd1);
         chk($sformatf("d%0d hold rdata", k), resp_rdata[k], sv_rd);
         chk($sformatf("d%0d hold err", k), 32'(resp_err[k]), 32'(sv_err));
         chk($sformatf("d%0d hold req_ready", k), 32'(req_ready[k]), 32'd0);
      end

      resp_ready[k] = 1'b1;
      @(posedge clk); #1;
      resp_ready[k] = 1'b0;
      req_valid[k]  = 1'b0;
      chk_idle_outputs(k, "after resp");
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int unsigned acc;
      int unsigned prev;
      logic [31:0] a;
      logic [31:0] d;
      int          r;

      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req_valid[k]  = 1'b0;
         req_we[k]     = 1'b0;
         req_addr[k]   = '0;
         req_wdata[k]  = '0;
         resp_ready[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) chk_idle_outputs(k, "reset");
      rst_n = 1'b1;

      // LATENCY=2: write then read back, request offered on the first edge out of reset.
      txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, acc);
      txn(0, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, acc);
      chk("d0 readback 0x10", resp_rdata[0], 32'h0);

      // LATENCY=0: write then immediate read.
      txn(1, 1'b1, 32'h0000_0000, 32'h1234_5678, 0, 1'b0, acc);
      txn(1, 1'b0, 32'h0000_0000, 32'h0, 0, 1'b0, acc);

      // Backpressure with a competing request held during the response.
      txn(0, 1'b0, 32'h0000_0010, 32'h0, 5, 1'b1, acc);
      txn(0, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, acc);

      // Misaligned and out-of-range writes leave word 0 untouched.
      txn(0, 1'b1, 32'h0000_0000, 32'hCAFE_0001, 0, 1'b0, acc);
      txn(0, 1'b1, 32'h0000_0402, 32'h1111_1111, 0, 1'b0, acc);
      txn(0, 1'b1, 32'h0000_0400, 32'h2222_2222, 0, 1'b0, acc);
      txn(0, 1'b0, 32'h0000_0000, 32'h0, 0, 1'b0, acc);

      // Reset during WAIT (LATENCY=4) discards the pending write.
      txn(2, 1'b1, 32'h0000_0020, 32'h1111_2222, 0, 1'b0, acc);
      req_valid[2] = 1'b1;
      req_we[2]    = 1'b1;
      req_addr[2]  = 32'h0000_0020;
      req_wdata[2] = 32'hAAAA_5555;
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      chk("d2 req_ready in WAIT", 32'(req_ready[2]), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_idle_outputs(2, "async reset");
      repeat (4) @(posedge clk);
      #1;
      chk_idle_outputs(2, "reset held");
      rst_n = 1'b1;
      txn(2, 1'b0, 32'h0000_0020, 32'h0, 0, 1'b0, acc);

      // Back-to-back traffic: one transaction every LATENCY+2 cycles.
      for (int k = 0; k < 3; k++) begin
         prev = 0;
         for (int i = 0; i < 6; i++) begin
            a = 32'(i % 3) << 2;
            d = $urandom();
            txn(k, (i < 3), a, d, 0, 1'b0, acc);
            if (i > 0) chk($sformatf("d%0d throughput step %0d", k, i), 32'(acc - prev), 32'(lat_of[k] + 2));
            prev = acc;
         end
      end

      // Random mix of reads, writes, errors, backpressure and ignored requests.
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else if (r == 1) a = (32'($urandom()) | 32'h0000_0400) & 32'hFFFF_FFFC;
            else             a = 32'($urandom_range(0, 15)) << 2;
            txn(k, 1'($urandom_range(0, 1)), a, $urandom(), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), acc);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, storage size in 32-bit words; SHALL be a power of two, 4..4096.
REQ-002 Parameter LATENCY, default 2, wait cycles between request acceptance and response; SHALL be 0..15.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n_i  input  1  reset; asynchronous assertion, active-low.
REQ-005 req_valid_i  input  1  initiator presents a request.
REQ-006 req_ready_o  output  1  responder can accept a request.
REQ-007 req_we_i  input  1  1 = write, 0 = read.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wdata_i  input  32  write data.
REQ-010 resp_valid_o  output  1  response available.
REQ-011 resp_ready_i  input  1  initiator takes the response.
REQ-012 resp_rdata_o  output  32  read data; 0 for writes and errors.
REQ-013 resp_err_o  output  1  1 = request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-015 req_ready_o SHALL be 1 only in IDLE; the request handshake is req_valid_i && req_ready_o at a rising edge (edge E0).
REQ-016 At E0 the block SHALL latch req_we_i, req_addr_i and req_wdata_i; later changes on req_* SHALL be ignored until the next IDLE.
REQ-017 At E0, LATENCY=0: IDLE->RESP; LATENCY>0: IDLE->WAIT with wait counter loaded to LATENCY-1.
REQ-018 In WAIT the counter SHALL decrement each edge; on the edge where it reads 0, WAIT->RESP. RESP is therefore entered exactly at edge E0+LATENCY.
REQ-019 On the edge entering RESP, the block SHALL perform the access: a write commits mem[addr[31:2]] <= wdata; a read registers mem[addr[31:2]] into resp_rdata_o.
REQ-020 Error condition: addr[1:0] != 0, or addr[31:2] >= DEPTH. On error there SHALL be no write, resp_rdata_o = 0, resp_err_o = 1.
REQ-021 resp_valid_o SHALL be 1 in RESP only; resp_rdata_o and resp_err_o SHALL stay stable while resp_valid_o=1 and resp_ready_i=0.
REQ-022 RESP->IDLE on the edge where resp_ready_i=1; resp_valid_o drops the following cycle; there SHALL be no IDLE bypass (maximum throughput one request per LATENCY+2 cycles).
REQ-023 Outside RESP, resp_rdata_o and resp_err_o SHALL be 0.
REQ-024 Write responses SHALL return resp_rdata_o=0 with resp_err_o=0 when in range.
REQ-025 req_valid_i asserted outside IDLE SHALL have no effect; the initiator holds it until req_ready_o=1.
REQ-026 A read of a word written by the immediately preceding request SHALL return the new data (write committed before the read's RESP edge).
REQ-027 Storage SHALL be an array of DEPTH 32-bit words, indexed by addr[log2(DEPTH)+1:2].

Reset
REQ-028 On rst_n_i=0 the FSM SHALL go to IDLE and the counter to 0 immediately; req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0 for as long as reset is held.
REQ-029 Reset in WAIT SHALL discard the pending request; a pending write SHALL NOT reach storage.
REQ-030 Reset SHALL NOT clear storage contents; a write committed before reset SHALL remain readable after reset.
REQ-031 The first request after deassertion SHALL be acceptable at the first rising edge with rst_n_i=1.

Verification
REQ-032 LATENCY=2: write 0x0000_0010 <= 0xDEAD_BEEF, then read 0x10 -> read resp_valid_o rises exactly 2 edges after acceptance; rdata 0xDEAD_BEEF, err 0.
REQ-033 LATENCY=0: read 0x0 after writing 0x1234_5678 -> resp_valid_o is 1 in the cycle right after the accept edge; rdata 0x1234_5678.
REQ-034 Backpressure: hold resp_ready_i=0 for 5 cycles -> resp_valid_o, rdata and err stay constant; req_ready_o=0 throughout; a new req_valid_i during that time is not accepted.
REQ-035 Errors, DEPTH=256: write to 0x0000_0402, then write to 0x0000_0400 -> both err=1, rdata 0; a later read of word 0 still returns its previous value.
REQ-036 LATENCY=4, write 0x20 <= 0xAAAA_5555: assert rst_n_i in WAIT -> outputs reset immediately; a read of 0x20 after reset returns the value before that write.
REQ-037 Back-to-back writes, then reads to 0x0/0x4/0x8 with resp_ready_i tied 1 -> one transaction every LATENCY+2 cycles, data returned in order.
